// File: rtl/sp_bram_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sp_bram_fifo_ctrl_pkg
// Shared definitions for the single-port BRAM FIFO controller:
//   - default BRAM geometry (depth and word width),
//   - output-register state encoding,
//   - clog2 constant function for pointer sizing.
// -----------------------------------------------------------------------------
package sp_bram_fifo_ctrl_pkg;

  localparam int BRAM_DEPTH      = 64;
  localparam int BRAM_DATA_WIDTH = 32;

  // Output register either holds a word for the consumer or it does not.
  typedef enum logic {
    OREG_EMPTY = 1'b0,
    OREG_VALID = 1'b1
  } oreg_state_t;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    for (v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/sp_bram_fifo_ctrl_wrap_ptr.sv
// -----------------------------------------------------------------------------
// sp_bram_fifo_ctrl_wrap_ptr
// Modulo-DEPTH pointer: advances by one on inc and wraps from DEPTH-1 to 0,
// so DEPTH need not be a power of two.
// Ports:
//   clk    in   rising-edge clock
//   n_clr  in   synchronous active-low reset (ptr -> 0)
//   inc    in   advance the pointer this cycle
//   ptr    out  current pointer value
// -----------------------------------------------------------------------------
module sp_bram_fifo_ctrl_wrap_ptr #(
  parameter int DEPTH     = 64,
  parameter int PTR_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 n_clr,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] ptr
);

  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(DEPTH - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!n_clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sp_bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sp_bram_fifo_ctrl
// Show-ahead FIFO controller in front of a single-port BRAM with combinational
// read data. One RAM access per cycle: an output-register refill (read) has
// priority over a push (write). The output register adds one word of storage,
// so total capacity is DEPTH+1.
//
// Optional feature: define SP_BRAM_FIFO_BYPASS_EN to let a push into an empty
// FIFO load pop_data directly (1-cycle push-to-pop_valid latency, no RAM
// access). Undefined: every word goes through the RAM (2-cycle latency).
//
// Ports:
//   clk, n_clr           clock, synchronous active-low reset
//   push_valid/ready/data upstream handshake
//   pop_valid/ready/data  downstream handshake, pop_data registered
//   ram_addr, ram_write_en, ram_read_en, ram_data_in, ram_data_out  BRAM port
//   ram_level            words held in the RAM (0..DEPTH)
//   full                 ram_level == DEPTH
// -----------------------------------------------------------------------------
module sp_bram_fifo_ctrl
  import sp_bram_fifo_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = BRAM_DATA_WIDTH,
  parameter int DEPTH         = BRAM_DEPTH,
  parameter int PTR_WIDTH     = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     n_clr,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [DATA_WIDTH-1:0]    push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_write_en,
  output logic                     ram_read_en,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out,
  output logic [PTR_WIDTH:0]       ram_level,
  output logic                     full
);

  localparam int LVL_W = PTR_WIDTH + 1;

  oreg_state_t          state_q, state_d;
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                 take;
  logic                 ram_empty;
  logic                 read_sel;
  logic                 bypass;
  logic                 write_sel;
  logic                 load;

  assign pop_valid = (state_q == OREG_VALID);
  assign ram_empty = (ram_level == '0);
  assign full      = (ram_level == LVL_W'(DEPTH));

  // Output register will be free at the end of this cycle.
  assign take     = ~pop_valid | pop_ready;
  // Refill whenever the register frees up and the RAM has data; this does not
  // look at push_valid, so a concurrent push stalls for one cycle.
  assign read_sel = n_clr & take & ~ram_empty;

`ifdef SP_BRAM_FIFO_BYPASS_EN
  assign bypass = n_clr & take & ram_empty & push_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push_ready = n_clr & ~read_sel & ~full;
  assign write_sel  = push_valid & push_ready & ~bypass;
  assign load       = read_sel | bypass;

  assign ram_read_en  = read_sel;
  assign ram_write_en = write_sel;
  assign ram_data_in  = push_data;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    ram_addr = '0;
    if (read_sel) begin
      ram_addr = ADDRESS_WIDTH'(rd_ptr);
    end else if (write_sel) begin
      ram_addr = ADDRESS_WIDTH'(wr_ptr);
    end
  end

  sp_bram_fifo_ctrl_wrap_ptr #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_wr_ptr (
    .clk   (clk),
    .n_clr (n_clr),
    .inc   (write_sel),
    .ptr   (wr_ptr)
  );

  sp_bram_fifo_ctrl_wrap_ptr #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rd_ptr (
    .clk   (clk),
    .n_clr (n_clr),
    .inc   (read_sel),
    .ptr   (rd_ptr)
  );

  // Output-register state machine.
  always_ff @(posedge clk) begin
    if (!n_clr) begin
      state_q <= OREG_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OREG_EMPTY: if (load)               state_d = OREG_VALID;
      OREG_VALID: if (pop_ready && !load) state_d = OREG_EMPTY;
      default:                            state_d = OREG_EMPTY;
    endcase
  end

  // NOTE: pop_data is a single visible register, so it is cleared on reset;
  // the RAM array itself is never reset, its contents are simply abandoned.
  always_ff @(posedge clk) begin
    if (!n_clr) begin
      pop_data  <= '0;
      ram_level <= '0;
    end else begin
      if (read_sel) begin
        pop_data <= ram_data_out;
      end else if (bypass) begin
        pop_data <= push_data;
      end
      // Read and write are mutually exclusive by construction.
      if (write_sel) begin
        ram_level <= ram_level + LVL_W'(1);
      end else if (read_sel) begin
        ram_level <= ram_level - LVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sp_bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sp_bram_fifo_ctrl
// Self-checking bench for sp_bram_fifo_ctrl with a behavioural BRAM model,
// a vector table, directed corner-case sequences and a randomized run against
// a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sp_bram_fifo_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int PW    = 6;

`ifdef SP_BRAM_FIFO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int LAT = BYPASS ? 1 : 2;

  logic          clk;
  logic          n_clr;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [AW-1:0] ram_addr;
  logic          ram_write_en;
  logic          ram_read_en;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic [PW:0]   ram_level;
  logic          full;

  sp_bram_fifo_ctrl #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .PTR_WIDTH     (PW)
  ) dut (
    .clk          (clk),
    .n_clr        (n_clr),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_data    (push_data),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .pop_data     (pop_data),
    .ram_addr     (ram_addr),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .ram_level    (ram_level),
    .full         (full)
  );

  // Behavioural single-port BRAM: synchronous write, combinational read.
  logic [DW-1:0] mem [DEPTH];
  assign ram_data_out = ram_read_en ? mem[ram_addr[PW-1:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr[PW-1:0]] <= ram_data_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          pv;
    logic [DW-1:0] pd;
    logic          pr;
    logic          e_rdy;
    logic          e_wen;
    logic          e_ren;
    logic          e_pv;
    logic [PW:0]   e_lvl;
    logic [DW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic pv, input logic [DW-1:0] pd, input logic pr,
                              input logic e_rdy, input logic e_wen, input logic e_ren,
                              input logic e_pv, input int e_lvl, input logic [DW-1:0] e_data);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pr = pr;
    v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_ren = e_ren; v.e_pv = e_pv;
    v.e_lvl = (PW+1)'(e_lvl); v.e_data = e_data;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_clr = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    step();
    step();
    n_clr = 1'b1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    push_valid = 1'b1;
    push_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = push_ready;
      step();
    end
    push_valid = 1'b0;
    check("push_accept", done, 1);
  endtask

  task automatic pop_word(output logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    d = '0;
    pop_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (pop_valid) begin
        done = 1'b1;
        d = pop_data;
      end
      step();
    end
    pop_ready = 1'b0;
    check("pop_available", done, 1);
  endtask

  vec_t          vecs [8];
  logic [DW-1:0] got_word;
  logic [DW-1:0] mq [$];

  initial begin
    n_clr = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;

    // ---------------- vector table (starts from an empty FIFO) -------------
`ifdef SP_BRAM_FIFO_BYPASS_EN
    vecs[0] = mk(1, 32'd11, 0,  1, 0, 0, 0, 0, 32'd0);
    vecs[1] = mk(1, 32'd22, 0,  1, 1, 0, 1, 0, 32'd11);
    vecs[2] = mk(1, 32'd33, 0,  1, 1, 0, 1, 1, 32'd11);
    vecs[3] = mk(0, 32'd0,  1,  0, 0, 1, 1, 2, 32'd11);
    vecs[4] = mk(0, 32'd0,  1,  0, 0, 1, 1, 1, 32'd22);
    vecs[5] = mk(0, 32'd0,  1,  1, 0, 0, 1, 0, 32'd33);
    vecs[6] = mk(0, 32'd0,  1,  1, 0, 0, 0, 0, 32'd0);
    vecs[7] = mk(1, 32'd44, 1,  1, 0, 0, 0, 0, 32'd0);
`else
    vecs[0] = mk(1, 32'd11, 0,  1, 1, 0, 0, 0, 32'd0);
    vecs[1] = mk(1, 32'd22, 0,  0, 0, 1, 0, 1, 32'd0);
    vecs[2] = mk(1, 32'd22, 0,  1, 1, 0, 1, 0, 32'd11);
    vecs[3] = mk(1, 32'd33, 0,  1, 1, 0, 1, 1, 32'd11);
    vecs[4] = mk(0, 32'd0,  1,  0, 0, 1, 1, 2, 32'd11);
    vecs[5] = mk(0, 32'd0,  1,  0, 0, 1, 1, 1, 32'd22);
    vecs[6] = mk(0, 32'd0,  1,  1, 0, 0, 1, 0, 32'd33);
    vecs[7] = mk(0, 32'd0,  1,  1, 0, 0, 0, 0, 32'd0);
`endif

    // ---------------- reset with pushes pending ----------------------------
    push_valid = 1'b1;
    push_data  = 32'hDEAD_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_write_en", ram_write_en, 0);
      check("rst_read_en", ram_read_en, 0);
      check("rst_push_ready", push_ready, 0);
      step();
    end
    @(negedge clk);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_level", ram_level, 0);
    check("rst_pop_data", pop_data, 0);
    check("rst_full", full, 0);
    push_valid = 1'b0;
    n_clr = 1'b1;
    step();

    // ---------------- table-driven vectors ---------------------------------
    for (int i = 0; i < 8; i++) begin
      push_valid = vecs[i].pv;
      push_data  = vecs[i].pd;
      pop_ready  = vecs[i].pr;
      @(negedge clk);
      check($sformatf("vec%0d_push_ready", i), push_ready, vecs[i].e_rdy);
      check($sformatf("vec%0d_write_en", i), ram_write_en, vecs[i].e_wen);
      check($sformatf("vec%0d_read_en", i), ram_read_en, vecs[i].e_ren);
      check($sformatf("vec%0d_pop_valid", i), pop_valid, vecs[i].e_pv);
      check($sformatf("vec%0d_level", i), ram_level, vecs[i].e_lvl);
      if (vecs[i].e_pv) check($sformatf("vec%0d_pop_data", i), pop_data, vecs[i].e_data);
      step();
    end

    // ---------------- single word latency ----------------------------------
    do_reset();
    begin
      int edges;
      push_valid = 1'b1;
      push_data  = 32'hA5A5_0001;
      @(negedge clk);
      check("single_push_ready", push_ready, 1);
      step();
      push_valid = 1'b0;
      edges = 1;
      while (!pop_valid && edges < 10) begin
        step();
        edges++;
      end
      check("single_latency", edges, LAT);
      check("single_pop_data", pop_data, 32'hA5A5_0001);
    end

    // ---------------- fill to DEPTH+1 and drain ----------------------------
    do_reset();
    for (int w = 1; w <= DEPTH + 1; w++) push_word(DW'(w));
    push_valid = 1'b1;
    push_data  = 32'd66;
    @(negedge clk);
    check("fill_level", ram_level, DEPTH);
    check("fill_full", full, 1);
    check("fill_push_ready", push_ready, 0);
    check("fill_write_en", ram_write_en, 0);
    step();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int w = 1; w <= DEPTH + 1; w++) begin
      @(negedge clk);
      check("drain_pop_valid", pop_valid, 1);
      check("drain_pop_data", pop_data, DW'(w));
      step();
    end
    @(negedge clk);
    check("drain_empty_valid", pop_valid, 0);
    check("drain_empty_level", ram_level, 0);
    step();
    pop_ready = 1'b0;

    // ---------------- read/write contention --------------------------------
    do_reset();
    for (int w = 0; w < 4; w++) push_word(32'hC000_0001 + DW'(w));
    push_valid = 1'b1;
    push_data  = 32'h0000_0077;
    pop_ready  = 1'b1;
    @(negedge clk);
    check("cont_level", ram_level, 3);
    check("cont_read_en", ram_read_en, 1);
    check("cont_write_en", ram_write_en, 0);
    check("cont_push_ready", push_ready, 0);
    step();
    pop_ready = 1'b0;
    @(negedge clk);
    check("cont_next_push_ready", push_ready, 1);
    check("cont_next_write_en", ram_write_en, 1);
    step();
    push_valid = 1'b0;
    pop_word(got_word); check("cont_order0", got_word, 32'hC000_0002);
    pop_word(got_word); check("cont_order1", got_word, 32'hC000_0003);
    pop_word(got_word); check("cont_order2", got_word, 32'hC000_0004);
    pop_word(got_word); check("cont_order3", got_word, 32'h0000_0077);

    // ---------------- mid-operation reset ----------------------------------
    do_reset();
    for (int w = 0; w < 11; w++) push_word(32'hB000_0000 + DW'(w));
    @(negedge clk);
    check("midrst_level_before", ram_level, 10);
    n_clr = 1'b0;
    step();
    @(negedge clk);
    check("midrst_level", ram_level, 0);
    check("midrst_pop_valid", pop_valid, 0);
    check("midrst_push_ready", push_ready, 0);
    n_clr = 1'b1;
    step();
    push_word(32'h0000_1234);
    pop_word(got_word);
    check("midrst_pop_data", got_word, 32'h0000_1234);

    // ---------------- randomized run vs reference model --------------------
    do_reset();
    mq.delete();
    begin
      int  sent, got, ram_cnt;
      bit  m_valid, tk, exp_rdy, acc;
      sent = 0; got = 0; m_valid = 1'b0;
      for (int cyc = 0; cyc < 6000 && got < 200; cyc++) begin
        push_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
        push_data  = 32'h5000_0000 + DW'(sent);
        pop_ready  = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        ram_cnt = mq.size() - int'(m_valid);
        tk      = !m_valid || pop_ready;
        exp_rdy = !(tk && ram_cnt > 0) && (ram_cnt < DEPTH);
        acc     = push_valid && exp_rdy;
        check("rnd_push_ready", push_ready, exp_rdy);
        check("rnd_pop_valid", pop_valid, m_valid);
        check("rnd_level", ram_level, ram_cnt);
        check("rnd_full", full, ram_cnt == DEPTH);
        check("rnd_one_access", ram_read_en && ram_write_en, 0);
        if (ram_read_en || ram_write_en) check("rnd_addr_range", ram_addr < DEPTH, 1);
        if (m_valid && pop_ready) begin
          check("rnd_pop_data", pop_data, mq[0]);
          void'(mq.pop_front());
          got++;
        end
        if (acc) begin
          mq.push_back(push_data);
          sent++;
        end
        if (tk) m_valid = (ram_cnt > 0) || (BYPASS && acc);
        step();
      end
      push_valid = 1'b0;
      pop_ready  = 1'b0;
      check("rnd_words_delivered", got, 200);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
